// File: rtl/apb_sram_pkg.sv
// Shared types and helpers for the APB-to-SRAM controller.
// Latency: none (definitions only).
// Backpressure: not applicable.
package apb_sram_pkg;

  localparam int DATA_W  = 32;
  localparam int SRAM_AW = 10;
  localparam int STRB_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_DATA,
    WR,
    RMW_RD,
    RMW_WR,
    NOP,
    ERR
  } state_e;

  // Access is rejected when it is not word aligned or falls past the last word.
  // depth is one bit wider than the word index so DEPTH=1024 is representable.
  function automatic logic addr_err(input logic [1:0]         byte_off,
                                    input logic [SRAM_AW-1:0] word_idx,
                                    input logic [SRAM_AW:0]   depth);
    return (byte_off != 2'b00) || ({1'b0, word_idx} >= depth);
  endfunction

endpackage

// File: rtl/apb_sram_strb_merge.sv
// Byte-lane merge of a new write word over the old SRAM word.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module apb_sram_strb_merge
  import apb_sram_pkg::*;
(
  input  logic [DATA_W-1:0] old_word_i,
  input  logic [DATA_W-1:0] new_word_i,
  input  logic [STRB_W-1:0] strb_i,
  output logic [DATA_W-1:0] merged_o
);

  // Each strobed lane takes the new byte, every other lane keeps the old one.
  always_comb begin
    merged_o = old_word_i;
    for (int n = 0; n < STRB_W; n++) begin
      if (strb_i[n]) begin
        merged_o[8*n +: 8] = new_word_i[8*n +: 8];
      end
    end
  end

endmodule

// File: rtl/apb_sram_ctrl.sv
// APB4 slave sequencing a single-port SRAM with 1-cycle registered read data.
// Latency: full write / no-op / error complete in the first access cycle; read and partial write take one wait state.
// Backpressure: pready is held low during the wait state; a started sequence always runs to completion.
module apb_sram_ctrl
  import apb_sram_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int PADDR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [PADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0]  pwdata,
  input  logic [STRB_W-1:0]  pstrb,
  output logic [DATA_W-1:0]  prdata,
  output logic               pready,
  output logic               pslverr,
  output logic               sram_en,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0]  sram_din,
  input  logic [DATA_W-1:0]  sram_dout
);

  state_e             state_q, state_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic               write_q, write_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0]  strb_q, strb_d;

  logic [SRAM_AW-1:0] paddr_idx;
  logic               setup;
  logic [DATA_W-1:0]  merged;

  assign paddr_idx = paddr[PADDR_W-1:2];
  // Only a genuine setup phase starts a transfer; a bare penable in IDLE is ignored.
  assign setup     = psel & ~penable;

  apb_sram_strb_merge u_merge (
    .old_word_i (sram_dout),
    .new_word_i (wdata_q),
    .strb_i     (strb_q),
    .merged_o   (merged)
  );

  // State and capture registers; reset returns to IDLE and clears the captures.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
    end
  end

  // Next-state decode; transfer fields are captured only on setup in IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          addr_d  = paddr_idx;
          write_d = pwrite;
          wdata_d = pwdata;
          strb_d  = pstrb;
          if (addr_err(paddr[1:0], paddr_idx, (SRAM_AW+1)'(DEPTH))) begin
            state_d = ERR;
          end else if (!pwrite) begin
            state_d = RD;
          end else if (pstrb == '1) begin
            state_d = WR;
          end else if (pstrb == '0) begin
            state_d = NOP;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      RD:      state_d = RD_DATA;
      RMW_RD:  state_d = RMW_WR;
      // RD_DATA, WR, RMW_WR, NOP and ERR all complete the transfer.
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state and captures only, never from live APB inputs.
  always_comb begin
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = '0;
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = (state_q == IDLE) ? '0 : addr_q;
    sram_din  = '0;
    case (state_q)
      RD: begin
        sram_en = 1'b1;
      end
      RD_DATA: begin
        pready = 1'b1;
        prdata = sram_dout;
      end
      WR: begin
        sram_en  = 1'b1;
        sram_we  = 1'b1;
        sram_din = wdata_q;
        pready   = 1'b1;
      end
      RMW_RD: begin
        sram_en = 1'b1;
      end
      RMW_WR: begin
        sram_en  = 1'b1;
        sram_we  = 1'b1;
        sram_din = merged;
        pready   = 1'b1;
      end
      NOP: begin
        pready = 1'b1;
      end
      ERR: begin
        pready  = 1'b1;
        pslverr = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb_sram_ctrl.sv
// Self-checking bench for apb_sram_ctrl with a behavioural 32x32 SRAM.
// Latency: n/a.
// Backpressure: every wait on pready is bounded.
module tb_apb_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        sram_en;
  logic        sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;

  int n_cmp = 0;
  int n_bad = 0;

  apb_sram_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: contents survive reset, registered read port does not.
  logic [31:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
  end
  always @(posedge clk) begin
    if (rst) begin
      sram_dout <= 32'h0;
    end else if (sram_en) begin
      if (sram_we) mem[sram_addr[4:0]] <= sram_din;
      else         sram_dout <= mem[sram_addr[4:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that ends the transfer.
  task automatic apb_xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int lat, output logic err,
                          output logic [31:0] rd, output logic en_seen,
                          output logic [31:0] din_seen, output logic [9:0] addr_seen);
    lat = 0; err = 1'b0; rd = 32'h0; en_seen = 1'b0; din_seen = 32'h0; addr_seen = 10'h0;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (sram_en) begin
        en_seen   = 1'b1;
        addr_seen = sram_addr;
        if (sram_we) din_seen = sram_din;
      end
      if (pready) begin
        lat = c;
        err = pslverr;
        rd  = prdata;
        break;
      end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          lat;
    logic        err;
    logic        en;
    logic [9:0]  eaddr;
    logic [31:0] rdata;
    logic [31:0] din;
  } vec_t;

  vec_t vecs[14];

  int          lat;
  logic        err;
  logic [31:0] rd;
  logic        en_seen;
  logic [31:0] din_seen;
  logic [9:0]  addr_seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //             wr    addr     wdata         strb  lat err en  eaddr rdata         din
    vecs[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 1, 1'b0, 1'b1, 10'd4, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b0, 12'h010, 32'h0,        4'h0, 2, 1'b0, 1'b1, 10'd4, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b1, 12'h010, 32'h11223344, 4'h5, 2, 1'b0, 1'b1, 10'd4, 32'h0,        32'hDE22BE44};
    vecs[3]  = '{1'b0, 12'h010, 32'h0,        4'h0, 2, 1'b0, 1'b1, 10'd4, 32'hDE22BE44, 32'h0};
    vecs[4]  = '{1'b0, 12'h080, 32'h0,        4'h0, 1, 1'b1, 1'b0, 10'd0, 32'h0,        32'h0};
    vecs[5]  = '{1'b1, 12'h013, 32'hFFFFFFFF, 4'hF, 1, 1'b1, 1'b0, 10'd0, 32'h0,        32'h0};
    vecs[6]  = '{1'b0, 12'h010, 32'h0,        4'h0, 2, 1'b0, 1'b1, 10'd4, 32'hDE22BE44, 32'h0};
    vecs[7]  = '{1'b1, 12'h004, 32'hCAFEF00D, 4'hF, 1, 1'b0, 1'b1, 10'd1, 32'h0,        32'hCAFEF00D};
    vecs[8]  = '{1'b1, 12'h004, 32'h55555555, 4'h0, 1, 1'b0, 1'b0, 10'd0, 32'h0,        32'h0};
    vecs[9]  = '{1'b0, 12'h004, 32'h0,        4'h0, 2, 1'b0, 1'b1, 10'd1, 32'hCAFEF00D, 32'h0};
    vecs[10] = '{1'b1, 12'h010, 32'hAABBCCDD, 4'hA, 2, 1'b0, 1'b1, 10'd4, 32'h0,        32'hAA22CC44};
    vecs[11] = '{1'b0, 12'h002, 32'h0,        4'h0, 1, 1'b1, 1'b0, 10'd0, 32'h0,        32'h0};
    vecs[12] = '{1'b0, 12'h010, 32'h0,        4'h0, 2, 1'b0, 1'b1, 10'd4, 32'hAA22CC44, 32'h0};
    vecs[13] = '{1'b1, 12'h3FC, 32'h12345678, 4'hF, 1, 1'b1, 1'b0, 10'd0, 32'h0,        32'h0};

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 12'h0; pwdata = 32'h0; pstrb = 4'h0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {29'h0, pready, pslverr, sram_en}, 32'h0);
    check("reset_we_addr", {21'h0, sram_we, sram_addr}, 32'h0);
    check("reset_prdata", prdata, 32'h0);
    check("reset_din", sram_din, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table, one idle cycle between transfers
    for (int i = 0; i < 14; i++) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
               lat, err, rd, en_seen, din_seen, addr_seen);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_pslverr", i), {31'h0, err}, {31'h0, vecs[i].err});
      check($sformatf("v%0d_sram_en", i), {31'h0, en_seen}, {31'h0, vecs[i].en});
      check($sformatf("v%0d_prdata", i), rd, vecs[i].rdata);
      if (vecs[i].en) begin
        check($sformatf("v%0d_sram_addr", i), {22'h0, addr_seen}, {22'h0, vecs[i].eaddr});
        if (vecs[i].wr) check($sformatf("v%0d_sram_din", i), din_seen, vecs[i].din);
      end
      @(posedge clk); #1;
    end

    // penable without a preceding setup must not start anything
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h000;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stray_penable_c%0d", c), {30'h0, pready, sram_en}, 32'h0);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    apb_xfer(1'b0, 12'h000, 32'h0, 4'h0, lat, err, rd, en_seen, din_seen, addr_seen);
    check("stray_word0_intact", rd, 32'h0);

    // Reset while the read is in its wait state
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h010;
    @(posedge clk); #1;
    penable = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("pre_reset_in_rd", {31'h0, sram_en}, 32'h1);
    @(negedge clk);
    check("midrst_ctrl", {30'h0, pready, sram_en}, 32'h0);
    check("midrst_prdata", prdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    apb_xfer(1'b1, 12'h07C, 32'h0BADF00D, 4'hF, lat, err, rd, en_seen, din_seen, addr_seen);
    check("w31_latency", 32'(lat), 32'd1);
    check("w31_addr", {22'h0, addr_seen}, 32'd31);
    check("w31_pslverr", {31'h0, err}, 32'h0);
    @(posedge clk); #1;
    apb_xfer(1'b0, 12'h07C, 32'h0, 4'h0, lat, err, rd, en_seen, din_seen, addr_seen);
    check("r31_latency", 32'(lat), 32'd2);
    check("r31_data", rd, 32'h0BADF00D);
    @(posedge clk); #1;
    apb_xfer(1'b1, 12'h07C, 32'h000000EE, 4'h1, lat, err, rd, en_seen, din_seen, addr_seen);
    check("rmw31_latency", 32'(lat), 32'd2);
    check("rmw31_din", din_seen, 32'h0BADF0EE);
    @(posedge clk); #1;
    apb_xfer(1'b0, 12'h07C, 32'h0, 4'h0, lat, err, rd, en_seen, din_seen, addr_seen);
    check("rmw31_readback", rd, 32'h0BADF0EE);

    // Back-to-back write then read with no idle cycle in between
    @(posedge clk); #1;
    apb_xfer(1'b1, 12'h000, 32'hA5A5A5A5, 4'hF, lat, err, rd, en_seen, din_seen, addr_seen);
    check("b2b_wr_latency", 32'(lat), 32'd1);
    check("b2b_wr_din", din_seen, 32'hA5A5A5A5);
    apb_xfer(1'b0, 12'h000, 32'h0, 4'h0, lat, err, rd, en_seen, din_seen, addr_seen);
    check("b2b_rd_latency", 32'(lat), 32'd2);
    check("b2b_rd_data", rd, 32'hA5A5A5A5);
    check("b2b_rd_pslverr", {31'h0, err}, 32'h0);

    // Errored and no-op writes must have left memory untouched
    check("mem_word1", mem[1], 32'hCAFEF00D);
    check("mem_word4", mem[4], 32'hAA22CC44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
